// File: rtl/ro_meas_pkg.sv
// ============================================================================
//  Module      : ro_meas_pkg
//  Description : Shared state encoding and default sizing for the ring-
//                oscillator measurement controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ro_meas_pkg;

    localparam int c_CNT_W_DEF      = 16;
    localparam int c_WIN_W_DEF      = 16;
    localparam int c_SETTLE_CYC_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ro_meas_sync.sv
// ============================================================================
//  Module      : ro_meas_sync
//  Description : Two-flop synchronizer for the divided ring-oscillator output
//                followed by a rising-edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_meas_sync (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= ro_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/ro_meas_ctrl.sv
// ============================================================================
//  Module      : ro_meas_ctrl
//  Description : Ring-oscillator frequency measurement: enable, settle, count
//                synchronized ro_in edges over a window, report the result.
//                Define RO_MEAS_SAT_EN for a saturating edge counter
//                (default build wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W_DEF,
    parameter int WIN_W      = c_WIN_W_DEF,
    parameter int SETTLE_CYC = c_SETTLE_CYC_DEF   // must be at least 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    // One down-counter times both the settle phase and the window.
    localparam int                c_TMR_W       = max_int(WIN_W, $clog2(SETTLE_CYC + 1));
    localparam logic [c_TMR_W-1:0] c_SETTLE_LOAD = c_TMR_W'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ro_en;
    logic [WIN_W-1:0]   r_win;
    logic [c_TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   r_count_res;
    logic               r_ovf_res;
    logic               w_rise;
    logic               w_accept;
    logic               w_tmr_zero;

    ro_meas_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_in),
        .rise  (w_rise)
    );

    assign w_accept   = (r_state == IDLE) && start && (win_len != '0);
    assign w_tmr_zero = (r_tmr == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = SETTLE;
            SETTLE:  if (w_tmr_zero) w_state_nxt = MEASURE;
            MEASURE: if (w_tmr_zero) w_state_nxt = DONE;
            DONE:                    w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if ((r_state == MEASURE) && w_rise) begin
            if (&r_cnt) begin
                w_ovf_nxt = 1'b1;
`ifdef RO_MEAS_SAT_EN
                w_cnt_nxt = r_cnt;
`else
                w_cnt_nxt = '0;
`endif
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ro_en     <= 1'b0;
            r_win       <= '0;
            r_tmr       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_count_res <= '0;
            r_ovf_res   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Registered so the ring enable never glitches on state decode.
            r_ro_en <= (w_state_nxt == SETTLE) || (w_state_nxt == MEASURE);
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_win <= win_len;
                        r_tmr <= c_SETTLE_LOAD;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                SETTLE: begin
                    r_tmr <= w_tmr_zero ? (c_TMR_W'(r_win) - 1'b1) : (r_tmr - 1'b1);
                end
                MEASURE: begin
                    r_tmr <= r_tmr - 1'b1;
                    // Result includes an edge counted on the window's last cycle.
                    if (w_tmr_zero) begin
                        r_count_res <= w_cnt_nxt;
                        r_ovf_res   <= w_ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ro_en = r_ro_en;
    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE);
    assign count = r_count_res;
    assign ovf   = r_ovf_res;

endmodule

`default_nettype wire
